// File: rtl/pe_spad_ctrl_if.sv
// pe_spad_ctrl_if -- bundle of the start/config inputs, the weight and
// ifmap streams, the filter/ifmap RF write and read ports, the MAC control
// strobes and the busy/done status of one PE scratchpad controller.
//   slave  : seen by the controller (config and stream inputs in, RF/MAC/status out)
//   master : seen by the environment driving the controller
interface pe_spad_ctrl_if #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 3
);
    logic                     i_start;
    logic [ADDR_BITWIDTH:0]   i_cfg_len;
    logic [7:0]               i_cfg_nout;

    logic                     i_filt_valid;
    logic                     o_filt_ready;
    logic [DATA_BITWIDTH-1:0] i_filt_data;

    logic                     i_ifm_valid;
    logic                     o_ifm_ready;
    logic [DATA_BITWIDTH-1:0] i_ifm_data;

    logic                     o_f_we;
    logic [ADDR_BITWIDTH-1:0] o_f_wa;
    logic [DATA_BITWIDTH-1:0] o_f_wd;
    logic [ADDR_BITWIDTH-1:0] o_f_ra;

    logic                     o_i_we;
    logic [ADDR_BITWIDTH-1:0] o_i_wa;
    logic [DATA_BITWIDTH-1:0] o_i_wd;
    logic [ADDR_BITWIDTH-1:0] o_i_ra;

    logic                     o_mac_en;
    logic                     o_mac_first;
    logic                     o_mac_last;
    logic                     o_busy;
    logic                     o_done;

    modport slave (
        input  i_start, i_cfg_len, i_cfg_nout,
        input  i_filt_valid, i_filt_data, i_ifm_valid, i_ifm_data,
        output o_filt_ready, o_ifm_ready,
        output o_f_we, o_f_wa, o_f_wd, o_f_ra,
        output o_i_we, o_i_wa, o_i_wd, o_i_ra,
        output o_mac_en, o_mac_first, o_mac_last, o_busy, o_done
    );

    modport master (
        output i_start, i_cfg_len, i_cfg_nout,
        output i_filt_valid, i_filt_data, i_ifm_valid, i_ifm_data,
        input  o_filt_ready, o_ifm_ready,
        input  o_f_we, o_f_wa, o_f_wd, o_f_ra,
        input  o_i_we, o_i_wa, o_i_wd, o_i_ra,
        input  o_mac_en, o_mac_first, o_mac_last, o_busy, o_done
    );
endinterface

// File: rtl/pe_spad_ctrl.sv
// pe_spad_ctrl -- scratchpad controller of a row-stationary PE.
// Loads S filter weights and S ifmap samples into two RFs, then produces N
// partial sums of length S. Between sums one new ifmap sample is written over
// the oldest slot and the read window slides by one (circular, modulo RC).
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset; also forces all outputs to 0
//   bus    : pe_spad_ctrl_if.slave -- start/config, weight and ifmap
//            streams, filter/ifmap RF ports, MAC strobes, busy/done
module pe_spad_ctrl #(
    parameter int DATA_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pe_spad_ctrl_if.slave  bus
);
    localparam int RC = 1 << ADDR_BITWIDTH;
    localparam int LW = ADDR_BITWIDTH + 1;

    typedef enum logic [2:0] {IDLE, LD_FILT, LD_IFM, COMPUTE, SHIFT, DONE} state_t;

    state_t                   state, state_nx;
    logic [ADDR_BITWIDTH-1:0] cnt, cnt_nx;
    logic [ADDR_BITWIDTH-1:0] base, base_nx;
    logic [7:0]               ocnt, ocnt_nx;
    logic [7:0]               nout, nout_nx;
    logic [LW-1:0]            slen, slen_nx;

    logic cnt_last;
    logic cfg_ok;

    assign cnt_last = ({1'b0, cnt} == (slen - LW'(1)));
    assign cfg_ok   = (bus.i_cfg_len != '0) && (bus.i_cfg_len <= LW'(RC)) &&
                      (bus.i_cfg_nout != 8'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
            ocnt  <= '0;
            nout  <= '0;
            slen  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            base  <= base_nx;
            ocnt  <= ocnt_nx;
            nout  <= nout_nx;
            slen  <= slen_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        base_nx  = base;
        ocnt_nx  = ocnt;
        nout_nx  = nout;
        slen_nx  = slen;

        bus.o_filt_ready = 1'b0;
        bus.o_ifm_ready  = 1'b0;
        bus.o_f_we       = 1'b0;
        bus.o_f_wa       = '0;
        bus.o_f_wd       = '0;
        bus.o_f_ra       = '0;
        bus.o_i_we       = 1'b0;
        bus.o_i_wa       = '0;
        bus.o_i_wd       = '0;
        bus.o_i_ra       = '0;
        bus.o_mac_en     = 1'b0;
        bus.o_mac_first  = 1'b0;
        bus.o_mac_last   = 1'b0;
        bus.o_busy       = (state != IDLE);
        bus.o_done       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_start && cfg_ok) begin
                    slen_nx  = bus.i_cfg_len;
                    nout_nx  = bus.i_cfg_nout;
                    cnt_nx   = '0;
                    base_nx  = '0;
                    ocnt_nx  = '0;
                    state_nx = LD_FILT;
                end
            end
            LD_FILT: begin
                bus.o_filt_ready = 1'b1;
                if (bus.i_filt_valid) begin
                    bus.o_f_we = 1'b1;
                    bus.o_f_wa = cnt;
                    bus.o_f_wd = bus.i_filt_data;
                    if (cnt_last) begin
                        cnt_nx   = '0;
                        state_nx = LD_IFM;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            LD_IFM: begin
                bus.o_ifm_ready = 1'b1;
                if (bus.i_ifm_valid) begin
                    bus.o_i_we = 1'b1;
                    bus.o_i_wa = cnt;
                    bus.o_i_wd = bus.i_ifm_data;
                    if (cnt_last) begin
                        cnt_nx   = '0;
                        base_nx  = '0;
                        state_nx = COMPUTE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // RF reads are combinational, so operands line up with mac_en.
                bus.o_mac_en    = 1'b1;
                bus.o_f_ra      = cnt;
                bus.o_i_ra      = base + cnt;
                bus.o_mac_first = (cnt == '0);
                bus.o_mac_last  = cnt_last;
                if (cnt_last) begin
                    cnt_nx = '0;
                    if (ocnt == (nout - 8'd1)) begin
                        state_nx = DONE;
                    end else begin
                        ocnt_nx  = ocnt + 8'd1;
                        state_nx = SHIFT;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SHIFT: begin
                // New sample lands one past the window end; with S == RC that
                // is the slot at base, which the finished sum no longer needs.
                bus.o_ifm_ready = 1'b1;
                if (bus.i_ifm_valid) begin
                    bus.o_i_we = 1'b1;
                    bus.o_i_wa = base + slen[ADDR_BITWIDTH-1:0];
                    bus.o_i_wd = bus.i_ifm_data;
                    base_nx    = base + 1'b1;
                    cnt_nx     = '0;
                    state_nx   = COMPUTE;
                end
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Reset quiets every output in the cycle it is asserted, so no RF
        // write or MAC strobe can escape while the state is being cleared.
        if (i_rst) begin
            bus.o_filt_ready = 1'b0;
            bus.o_ifm_ready  = 1'b0;
            bus.o_f_we       = 1'b0;
            bus.o_f_wa       = '0;
            bus.o_f_wd       = '0;
            bus.o_f_ra       = '0;
            bus.o_i_we       = 1'b0;
            bus.o_i_wa       = '0;
            bus.o_i_wd       = '0;
            bus.o_i_ra       = '0;
            bus.o_mac_en     = 1'b0;
            bus.o_mac_first  = 1'b0;
            bus.o_mac_last   = 1'b0;
            bus.o_busy       = 1'b0;
            bus.o_done       = 1'b0;
        end
    end
endmodule

// File: doc/pe_spad_ctrl.md
PE_SPAD_CTRL -- requirements
Module: pe_spad_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 8, RF word width.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 3, RF address width; RC = 2^ADDR_BITWIDTH entries per RF.
REQ-003 SHALL have ports:
- i_clk  in  1  sole clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_cfg_len  in  ADDR_BITWIDTH+1  filter length S, legal 1..RC
- i_cfg_nout  in  8  output count N, legal 1..255
- i_filt_valid / o_filt_ready / i_filt_data  in/out/in  1/1/DATA_BITWIDTH  weight stream
- i_ifm_valid / o_ifm_ready / i_ifm_data  in/out/in  1/1/DATA_BITWIDTH  ifmap stream
- o_f_we, o_f_wa, o_f_wd, o_f_ra  out  1/ADDR/DATA/ADDR  filter RF write and read port
- o_i_we, o_i_wa, o_i_wd, o_i_ra  out  1/ADDR/DATA/ADDR  ifmap RF write and read port
- o_mac_en, o_mac_first, o_mac_last  out  1 each  MAC operand-valid, clear-accumulator, psum-complete
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at job end

Function
REQ-004 SHALL implement FSM states IDLE, LD_FILT, LD_IFM, COMPUTE, SHIFT, DONE.
REQ-005 IDLE: on i_start with 1<=i_cfg_len<=RC and i_cfg_nout>=1, SHALL latch S and N, clear cnt, base and ocnt, and go to LD_FILT; on an illegal config, i_start SHALL be ignored.
REQ-006 i_start outside IDLE SHALL be ignored; the config inputs SHALL be used only at the latch point.
REQ-007 Handshake completes when valid && ready in the same cycle; the ready outputs SHALL NOT depend on valid.
REQ-008 LD_FILT: o_filt_ready=1; per handshake o_f_we=1, o_f_wa=cnt, o_f_wd=i_filt_data (combinational, same cycle); cnt++.
REQ-009 LD_FILT: the handshake with cnt==S-1 SHALL go to LD_IFM with cnt=0.
REQ-010 LD_IFM: o_ifm_ready=1; per handshake o_i_we=1, o_i_wa=cnt, o_i_wd=i_ifm_data; cnt++; the handshake with cnt==S-1 SHALL go to COMPUTE with cnt=0 and base=0.
REQ-011 COMPUTE: each cycle o_mac_en=1, o_f_ra=cnt, o_i_ra=(base+cnt) mod RC, o_mac_first=(cnt==0), o_mac_last=(cnt==S-1); cnt++.
REQ-012 COMPUTE lasts exactly S cycles; first and last SHALL both be high when S==1.
REQ-013 After the cnt==S-1 cycle: if ocnt==N-1, go to DONE; otherwise ocnt++ and go to SHIFT.
REQ-014 SHIFT: o_ifm_ready=1; on handshake o_i_we=1, o_i_wa=(base+S) mod RC, base=(base+1) mod RC, cnt=0, go to COMPUTE; stall with no side effects while valid is low.
REQ-015 When S==RC, the SHIFT write address equals base (the oldest slot, already consumed); this is legal.
REQ-016 Address arithmetic SHALL wrap modulo RC with no overflow flag.
REQ-017 DONE: o_done=1 for exactly one cycle, then go to IDLE.
REQ-018 Outside the stated conditions, every *_we, *_ready and o_mac_* output SHALL be 0; unused address and data outputs SHALL be 0.
REQ-019 In COMPUTE, RF read data is combinational, so the operands are valid in the same cycle as o_mac_en.

Reset
REQ-020 i_rst high at a clock edge SHALL force IDLE and clear cnt, base, ocnt, S and N; it takes priority over every event in that cycle, including mid-job.
REQ-021 During and after reset, all outputs SHALL be 0.
REQ-022 Reset SHALL NOT issue RF writes; RF contents are cleared by the RF's own reset.

Verification
REQ-023 S=3, N=1, weights 1,2,3, ifmap 4,5,6 -> f_wa 0,1,2 then i_wa 0,1,2; COMPUTE 3 cycles, f_ra 0,1,2, i_ra 0,1,2, first on cycle 1, last on cycle 3; o_done 1 cycle later.
REQ-024 S=3, N=3, RC=8 -> SHIFT writes i_wa 3 then 4; second COMPUTE i_ra 1,2,3; third COMPUTE i_ra 2,3,4; exactly 9 o_mac_en cycles.
REQ-025 S=8=RC, N=3 -> SHIFT i_wa 0 then 1; second COMPUTE i_ra 1..7,0 (wrap).
REQ-026 S=1, N=2 -> each COMPUTE is 1 cycle with first=last=1.
REQ-027 Invalid configs (S=0, S=9, N=0) with i_start -> o_busy stays 0.
REQ-028 Valid deasserted for 5 cycles in LD_FILT and in SHIFT -> no writes and no state change; i_rst in COMPUTE -> IDLE next cycle and all outputs 0.
